// File: rtl/matrix_scan_ctrl_if.sv
// Host-side bus of the matrix scanner: back-buffer column writes and the
// front/back swap handshake with its frame-end status.
interface matrix_scan_ctrl_if #(
  parameter int CW    = 5,
  parameter int ROW_W = 16
);
  logic             wr_en;
  logic [CW-1:0]    wr_addr;
  logic [ROW_W-1:0] wr_data;
  logic             swap_req;
  logic             swap_pending;
  logic             frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req,
    input  swap_pending, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req,
    output swap_pending, frame_done
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Double-buffered column scanner for cascaded LED matrix panels.
// States: BLANK = rows dark, COLUMN_CLK low | DRIVE = front column on rows, COLUMN_CLK high.
module matrix_scan_ctrl #(
  parameter int NUM_PANELS     = 4,
  parameter int COLS_PER_PANEL = 8,
  parameter int ROW_W          = 16,
  parameter int BLANK_CYCLES   = 1,
  parameter int DRIVE_CYCLES   = 1,
  parameter int REVERSE        = 0
) (
  input  logic                  Divided_CLK,
  input  logic                  RESET,
  input  logic                  enable,
  matrix_scan_ctrl_if.slave     bus,
  output logic [ROW_W-1:0]      out_column,
  output logic                  COLUMN_CLK,
  output logic [NUM_PANELS-1:0] column_seg
);

  localparam int N      = NUM_PANELS * COLS_PER_PANEL;
  localparam int CW     = (N > 1) ? $clog2(N) : 1;
  localparam int PH_MAX = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] DRIVE_LAST = PW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] LOCAL_MASK = CW'(COLS_PER_PANEL - 1);
  localparam logic [CW:0]   N_LIMIT    = (CW + 1)'(N);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [CW-1:0]    col_q, col_d;
  logic             ptr_q, ptr_d;
  logic             swap_pending_q, swap_pending_d;
  logic             frame_done_q, frame_done_d;
  logic [ROW_W-1:0] out_column_q, out_column_d;
  logic             column_clk_q, column_clk_d;
  logic [NUM_PANELS-1:0] column_seg_q, column_seg_d;
  logic [ROW_W-1:0] mem_q [2][N];
  logic [ROW_W-1:0] mem_d [2][N];

  logic [CW-1:0]    map_col;
  logic             frame_end;

  // State register
  always_ff @(posedge Divided_CLK) begin
    if (RESET) begin
      state_q <= ST_BLANK;
      ph_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      col_q   <= col_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    col_d   = col_q;
    if (!enable) begin
      state_d = ST_BLANK;
      ph_d    = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (ph_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (ph_q == DRIVE_LAST) begin
            state_d = ST_BLANK;
            ph_d    = '0;
            col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          ph_d    = '0;
          col_d   = '0;
        end
      endcase
    end
  end

  // Reversal stays inside a panel, so flipping the local index bits is enough.
  assign map_col   = (REVERSE != 0) ? (col_d ^ LOCAL_MASK) : col_d;
  assign frame_end = enable && (state_q == ST_DRIVE) && (ph_q == DRIVE_LAST)
                     && (col_q == COL_LAST);

  // Output logic: registered from the next state so outputs line up with state_q
  always_comb begin
    out_column_d = '0;
    column_clk_d = 1'b0;
    column_seg_d = '1;
    frame_done_d = 1'b0;
    if (state_d == ST_DRIVE) begin
      column_clk_d = 1'b1;
      out_column_d = (state_q == ST_BLANK) ? mem_q[ptr_q][map_col] : out_column_q;
      for (int p = 0; p < NUM_PANELS; p++) begin
        if (col_d == CW'(p * COLS_PER_PANEL)) column_seg_d[p] = 1'b0;
      end
      frame_done_d = (col_d == COL_LAST) && (ph_d == DRIVE_LAST);
    end
  end

  // Buffers and swap: a write on the swap edge still targets the old back buffer
  always_comb begin
    mem_d          = mem_q;
    ptr_d          = ptr_q;
    swap_pending_d = swap_pending_q | bus.swap_req;
    if (bus.wr_en && ({1'b0, bus.wr_addr} < N_LIMIT)) begin
      mem_d[~ptr_q][bus.wr_addr] = bus.wr_data;
    end
    if (frame_end && swap_pending_q) begin
      ptr_d          = ~ptr_q;
      swap_pending_d = 1'b0;
    end
  end

  always_ff @(posedge Divided_CLK) begin
    if (RESET) begin
      ptr_q          <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      out_column_q   <= '0;
      column_clk_q   <= 1'b0;
      column_seg_q   <= '1;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else begin
      ptr_q          <= ptr_d;
      swap_pending_q <= swap_pending_d;
      frame_done_q   <= frame_done_d;
      out_column_q   <= out_column_d;
      column_clk_q   <= column_clk_d;
      column_seg_q   <= column_seg_d;
      mem_q          <= mem_d;
    end
  end

  assign out_column       = out_column_q;
  assign COLUMN_CLK       = column_clk_q;
  assign column_seg       = column_seg_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl: three configurations, a frame model with a
// scoreboard of expected drive patterns, and per-cycle output checks.
module tb_matrix_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        wr_en = 1'b0;
  logic        swap_req = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  int cur_np = 4, cur_n = 32, cur_b = 1, cur_d = 1, cur_rev = 0;

  logic [15:0] m_front [32];
  logic [15:0] m_back  [32];
  bit          m_pend;
  logic [15:0] exp_q [$];

  matrix_scan_ctrl_if #(.CW(5), .ROW_W(16)) ifa ();
  matrix_scan_ctrl_if #(.CW(5), .ROW_W(16)) ifb ();
  matrix_scan_ctrl_if #(.CW(5), .ROW_W(16)) ifc ();

  assign ifa.wr_en    = wr_en && (sel == 0);
  assign ifa.wr_addr  = wr_addr;
  assign ifa.wr_data  = wr_data;
  assign ifa.swap_req = swap_req && (sel == 0);
  assign ifb.wr_en    = wr_en && (sel == 1);
  assign ifb.wr_addr  = wr_addr;
  assign ifb.wr_data  = wr_data;
  assign ifb.swap_req = swap_req && (sel == 1);
  assign ifc.wr_en    = wr_en && (sel == 2);
  assign ifc.wr_addr  = wr_addr;
  assign ifc.wr_data  = wr_data;
  assign ifc.swap_req = swap_req && (sel == 2);

  logic [15:0] out_a, out_b, out_c;
  logic        cc_a, cc_b, cc_c;
  logic [3:0]  seg_a, seg_c;
  logic [2:0]  seg_b;

  matrix_scan_ctrl u_a (
    .Divided_CLK(clk), .RESET(rst && (sel == 0)), .enable(en && (sel == 0)),
    .bus(ifa), .out_column(out_a), .COLUMN_CLK(cc_a), .column_seg(seg_a)
  );

  matrix_scan_ctrl #(.NUM_PANELS(3), .REVERSE(1)) u_b (
    .Divided_CLK(clk), .RESET(rst && (sel == 1)), .enable(en && (sel == 1)),
    .bus(ifb), .out_column(out_b), .COLUMN_CLK(cc_b), .column_seg(seg_b)
  );

  matrix_scan_ctrl #(.BLANK_CYCLES(2), .DRIVE_CYCLES(3)) u_c (
    .Divided_CLK(clk), .RESET(rst && (sel == 2)), .enable(en && (sel == 2)),
    .bus(ifc), .out_column(out_c), .COLUMN_CLK(cc_c), .column_seg(seg_c)
  );

  logic [15:0] o_out;
  logic        o_clk, o_fd, o_pend;
  logic [3:0]  o_seg;

  always_comb begin
    case (sel)
      1: begin
        o_out = out_b; o_clk = cc_b; o_seg = {1'b0, seg_b};
        o_fd = ifb.frame_done; o_pend = ifb.swap_pending;
      end
      2: begin
        o_out = out_c; o_clk = cc_c; o_seg = seg_c;
        o_fd = ifc.frame_done; o_pend = ifc.swap_pending;
      end
      default: begin
        o_out = out_a; o_clk = cc_a; o_seg = seg_a;
        o_fd = ifa.frame_done; o_pend = ifa.swap_pending;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int col, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cfg=%0d col=%0d observed=%0h expected=%0h", tag, sel, col, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_seg(input bit drive, input int col);
    logic [3:0] s;
    s = 4'((1 << cur_np) - 1);
    if (drive && (col % 8 == 0)) s[col / 8] = 1'b0;
    return s;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    m_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_swap();
    logic [15:0] t;
    for (int i = 0; i < 32; i++) begin
      t = m_front[i];
      m_front[i] = m_back[i];
      m_back[i] = t;
    end
  endtask

  task automatic push_frame();
    for (int c = 0; c < cur_n; c++) begin
      int m;
      m = (cur_rev != 0) ? (c / 8) * 8 + 7 - (c % 8) : c;
      exp_q.push_back(m_front[m]);
    end
  endtask

  task automatic check_idle(input string tag, input int col);
    chk({tag, "_clk"}, col, o_clk, 0);
    chk({tag, "_out"}, col, o_out, 0);
    chk({tag, "_seg"}, col, o_seg, exp_seg(1'b0, col));
    chk({tag, "_frame_done"}, col, o_fd, 0);
    chk({tag, "_pending"}, col, o_pend, m_pend);
  endtask

  // One frame from its first BLANK cycle; optional requests at the first cycle
  // and at the swap edge; stop_col >= 0 returns just before that column's BLANK.
  task automatic run_frame(input bit wr_s, input bit sw_s, input bit wr_e, input bit sw_e,
                           input logic [4:0] wa, input logic [15:0] wd, input int stop_col);
    logic [15:0] e;
    push_frame();
    for (int c = 0; c < cur_n; c++) begin
      if (c == stop_col) begin
        exp_q.delete();
        return;
      end
      for (int b = 0; b < cur_b; b++) begin
        check_idle("blank", c);
        if (c == 0 && b == 0) begin
          wr_en = wr_s; wr_addr = wa; wr_data = wd; swap_req = sw_s;
        end
        tick();
        wr_en = 1'b0; swap_req = 1'b0;
        if (c == 0 && b == 0) begin
          if (wr_s && wa < cur_n) m_back[wa] = wd;
          if (sw_s) m_pend = 1'b1;
        end
      end
      e = exp_q.pop_front();
      for (int d = 0; d < cur_d; d++) begin
        bit last;
        last = (c == cur_n - 1) && (d == cur_d - 1);
        chk("drive_clk", c, o_clk, 1);
        chk("drive_out", c, o_out, e);
        chk("drive_seg", c, o_seg, exp_seg(1'b1, c));
        chk("frame_done", c, o_fd, last);
        chk("drive_pending", c, o_pend, m_pend);
        if (last) begin
          wr_en = wr_e; wr_addr = wa; wr_data = wd; swap_req = sw_e;
        end
        tick();
        wr_en = 1'b0; swap_req = 1'b0;
        if (last) begin
          if (wr_e && wa < cur_n) m_back[wa] = wd;
          if (m_pend) begin
            m_swap();
            m_pend = 1'b0;
          end else if (sw_e) begin
            m_pend = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 16'hDEAD; swap_req = 1'b1;
    tick();
    tick();
    m_clear();
    check_idle("reset", 0);
    rst = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic select(input int s, input int np, input int b, input int d, input int rev);
    sel = s; cur_np = np; cur_n = np * 8; cur_b = b; cur_d = d; cur_rev = rev;
    en = 1'b0;
    tick();
  endtask

  initial begin
    m_clear();

    // Defaults: plain scan, double buffering, swap-edge events
    select(0, 4, 1, 1, 0);
    do_reset();
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);
    run_frame(1, 1, 0, 0, 5'd3, 16'hA5A5, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);
    run_frame(0, 1, 1, 1, 5'd0, 16'h00FF, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);

    // Disable at col 17, request a swap while idle, then resume from col 0
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, 17);
    en = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      check_idle("disabled", 0);
      if (i == 1) swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      if (i == 1) m_pend = 1'b1;
    end
    en = 1'b1;
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);

    // Reset at col 10 aborts the frame and clears both buffers
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, 10);
    rst = 1'b1;
    tick();
    m_clear();
    check_idle("midreset", 0);
    rst = 1'b0;
    run_frame(0, 1, 0, 0, 5'd0, 16'h0, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);

    // Three panels, reversed order, out-of-range write
    select(1, 3, 1, 1, 1);
    do_reset();
    run_frame(1, 1, 0, 0, 5'd7, 16'h8001, -1);
    run_frame(1, 1, 0, 0, 5'd24, 16'hFFFF, -1);
    run_frame(0, 1, 0, 0, 5'd0, 16'h0, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);

    // Longer blank/drive phases
    select(2, 4, 2, 3, 0);
    do_reset();
    run_frame(1, 1, 0, 0, 5'd5, 16'h1234, -1);
    run_frame(0, 0, 0, 0, 5'd0, 16'h0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PANELS, default 4, number of cascaded 8-column matrix panels.
REQ-002 The block SHALL have parameter COLS_PER_PANEL, default 8, columns per panel (power of 2).
REQ-003 The block SHALL have parameter ROW_W, default 16, bits per column pattern.
REQ-004 The block SHALL have parameter BLANK_CYCLES, default 1, blanking cycles per column (>=1).
REQ-005 The block SHALL have parameter DRIVE_CYCLES, default 1, drive cycles per column (>=1).
REQ-006 The block SHALL have parameter REVERSE, default 0; 1 means panel-local column order is reversed.
REQ-007 The block SHALL use N = NUM_PANELS*COLS_PER_PANEL and CW = clog2(N) as derived widths.
REQ-008 The block SHALL have port Divided_CLK  input  1  clock; all logic on rising edge.
REQ-009 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-010 The block SHALL have port enable  input  1  scan enable.
REQ-011 The block SHALL have port wr_en  input  1  back-buffer write strobe.
REQ-012 The block SHALL have port wr_addr  input  CW  global column index of write.
REQ-013 The block SHALL have port wr_data  input  ROW_W  column pattern to write.
REQ-014 The block SHALL have port swap_req  input  1  request front/back buffer swap.
REQ-015 The block SHALL have port out_column  output  ROW_W  registered row drive pattern.
REQ-016 The block SHALL have port COLUMN_CLK  output  1  column shift clock, high during DRIVE.
REQ-017 The block SHALL have port column_seg  output  NUM_PANELS  active-low panel-start strobe.
REQ-018 The block SHALL have port swap_pending  output  1  swap requested, not yet executed.
REQ-019 The block SHALL have port frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-020 The block SHALL hold two N x ROW_W buffers, front (displayed) and back (written), selected by a 1-bit pointer.
REQ-021 When wr_en=1 and wr_addr<N, the block SHALL write wr_data to back[wr_addr] at the clock edge; when wr_addr>=N the write SHALL be ignored.
REQ-022 The FSM SHALL have states BLANK and DRIVE with phase counter ph and column counter col (0..N-1).
REQ-023 In BLANK: out_column=0, COLUMN_CLK=0, column_seg all ones; after BLANK_CYCLES cycles the FSM SHALL move to DRIVE.
REQ-024 On entry to DRIVE: out_column=front[map(col)], COLUMN_CLK=1; out_column SHALL be held for DRIVE_CYCLES cycles.
REQ-025 map(col) SHALL equal col when REVERSE=0; otherwise it SHALL equal panel base + (COLS_PER_PANEL-1-local index).
REQ-026 During DRIVE of a column with local index 0 of panel p, column_seg[p] SHALL be 0; all other bits SHALL be 1.
REQ-027 At the end of DRIVE the FSM SHALL go to BLANK and col SHALL increment, wrapping from N-1 to 0.
REQ-028 The frame period SHALL be N*(BLANK_CYCLES+DRIVE_CYCLES) cycles.
REQ-029 swap_req=1 SHALL set swap_pending; a swap_req while pending SHALL have no further effect.
REQ-030 On the last DRIVE cycle of col N-1, frame_done SHALL pulse for 1 cycle, and if swap_pending=1 the pointer SHALL toggle and swap_pending SHALL clear on the same edge.
REQ-031 A swap_req on the swap edge SHALL be absorbed into that swap.
REQ-032 A write on the swap edge SHALL land in the pre-swap back buffer, so it is displayed in the next frame.
REQ-033 When enable=0, the FSM SHALL enter or stay in BLANK with col=0 and ph=0; writes and swap requests SHALL still be accepted, and no swap SHALL execute.
REQ-034 When enable rises, scanning SHALL restart at col 0 with a full BLANK phase.

Reset
REQ-035 When RESET=1 at an edge, the block SHALL set state=BLANK, col=0, ph=0, pointer=0, both buffers all zero, out_column=0, COLUMN_CLK=0, column_seg all ones, swap_pending=0, and frame_done=0.
REQ-036 RESET SHALL override wr_en, swap_req and enable in the same cycle; a reset mid-frame SHALL abort the frame with no frame_done.

Verification
REQ-037 Reset-and-scan check (defaults, enable=1, no writes): out_column=0 always; COLUMN_CLK toggles 0,1; frame_done pulses every 64 cycles; column_seg = 1110, 1101, 1011, 0111 on cols 0, 8, 16, 24.
REQ-038 Double-buffer check: write back[3]=16'hA5A5, then swap_req. Before the frame end col 3 drives 0; the frame after the swap drives 16'hA5A5 at col 3; swap_pending clears on the frame_done edge.
REQ-039 Simultaneous-events check: swap_req and a write of back[0]=16'h00FF on the swap edge give exactly one swap and 16'h00FF at col 0 of the next frame.
REQ-040 REVERSE=1 check: with front[7]=16'h8001, col 0 drives 16'h8001; an out-of-range write (wr_addr=N when N<2^CW) leaves all buffer contents unchanged.
REQ-041 Mid-operation check: enable=0 at col 17 gives out_column=0 and COLUMN_CLK=0 until re-enabled, then the scan restarts at col 0; RESET at col 10 clears all outputs next cycle with no frame_done.
REQ-042 Timing check (BLANK_CYCLES=2, DRIVE_CYCLES=3): COLUMN_CLK is low 2 cycles and high 3 cycles; frame_done pulses every 160 cycles.
